// File: rtl/pipe_ctrl_pkg.sv
// pipe_pkg: shared stage metadata, forwarding-select encoding and width defaults for pipe_ctrl.
package pipe_pkg;
  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_RADDR_W = 5;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_E = 2'd1, FWD_W = 2'd2} fwd_sel_t;
  typedef struct packed {
    logic valid;
    logic [DEFAULT_RADDR_W-1:0] rd;
    logic rd_we;
    logic is_load;
  } stage_meta_t;
  function automatic logic writes_src(stage_meta_t m, logic [DEFAULT_RADDR_W-1:0] src);
    return m.valid && m.rd_we && m.rd == src && src != '0;
  endfunction
endpackage

// File: rtl/pipe_ctrl_hazard.sv
// pipe_hazard: combinational data-hazard detection and operand-forwarding selects (PIPE_CTRL_FORWARD_EN).
module pipe_hazard
  import pipe_pkg::*;
(
  input  logic [DEFAULT_RADDR_W-1:0] d_rs1,
  input  logic [DEFAULT_RADDR_W-1:0] d_rs2,
  input  logic                       d_use_rs1,
  input  logic                       d_use_rs2,
  input  stage_meta_t                e_meta,
  input  stage_meta_t                w_meta,
  output logic                       hazard,
  output fwd_sel_t                   fwd_rs1_sel,
  output fwd_sel_t                   fwd_rs2_sel
);
  logic e1, e2, w1, w2, load_use;
  assign e1 = writes_src(e_meta, d_rs1);
  assign e2 = writes_src(e_meta, d_rs2);
  assign w1 = writes_src(w_meta, d_rs1);
  assign w2 = writes_src(w_meta, d_rs2);
  assign load_use = e_meta.valid && e_meta.is_load && e_meta.rd != '0 &&
                    ((d_use_rs1 && e_meta.rd == d_rs1) || (d_use_rs2 && e_meta.rd == d_rs2));
`ifdef PIPE_CTRL_FORWARD_EN
  assign hazard = load_use;
  assign fwd_rs1_sel = (e1 && !e_meta.is_load) ? FWD_E : w1 ? FWD_W : FWD_RF;
  assign fwd_rs2_sel = (e2 && !e_meta.is_load) ? FWD_E : w2 ? FWD_W : FWD_RF;
`else
  // a load that writes rd is already covered by the E match; the extra term only keeps the load flag in use
  assign hazard = (d_use_rs1 && (e1 || w1)) || (d_use_rs2 && (e2 || w2)) || (load_use && e_meta.rd_we);
  assign fwd_rs1_sel = FWD_RF;
  assign fwd_rs2_sel = FWD_RF;
`endif
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: four-stage pipeline controller (PC, valids, enables, flush/stall priority); forwarding via PIPE_CTRL_FORWARD_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int                XLEN     = DEFAULT_XLEN,
  parameter int                RADDR_W  = DEFAULT_RADDR_W,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int                PC_STEP  = 1,
  parameter int                CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall_ext,
  input  logic [RADDR_W-1:0] d_rs1,
  input  logic [RADDR_W-1:0] d_rs2,
  input  logic               d_use_rs1,
  input  logic               d_use_rs2,
  input  logic [RADDR_W-1:0] d_rd,
  input  logic               d_rd_we,
  input  logic               d_is_load,
  input  logic               e_busy,
  input  logic               e_jump_taken,
  input  logic [XLEN-1:0]    e_jump_dest,
  output logic [XLEN-1:0]    pc,
  output logic               f_en,
  output logic               d_en,
  output logic               e_en,
  output logic               w_en,
  output logic               d_valid,
  output logic               e_valid,
  output logic               w_valid,
  output logic [1:0]         fwd_rs1_sel,
  output logic [1:0]         fwd_rs2_sel,
  output logic [CNT_W-1:0]   retired,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_cycles
);
  stage_meta_t e_meta, w_meta, d_meta;
  fwd_sel_t h_rs1, h_rs2;
  logic hazard, flush, run;
  pipe_hazard u_hazard (
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .e_meta(e_meta), .w_meta(w_meta), .hazard(hazard),
    .fwd_rs1_sel(h_rs1), .fwd_rs2_sel(h_rs2)
  );
  assign d_meta = '{valid: d_valid, rd: d_rd, rd_we: d_rd_we, is_load: d_is_load};
  assign e_valid = e_meta.valid;
  assign w_valid = w_meta.valid;
  assign run = rstn && !stall_ext;
  assign flush = e_meta.valid && !e_busy && e_jump_taken;
  // a flush overrides both the busy hold and the interlock: the stalled instructions are being killed
  always_comb begin
    f_en = run && (flush || (!e_busy && !hazard));
    d_en = f_en;
    e_en = run && (flush || !e_busy);
    w_en = run;
    fwd_rs1_sel = rstn ? h_rs1 : FWD_RF;
    fwd_rs2_sel = rstn ? h_rs2 : FWD_RF;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc <= RESET_PC;
      d_valid <= 1'b0;
      e_meta <= '0;
      w_meta <= '0;
      retired <= '0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else if (stall_ext) begin
      stall_cycles <= stall_cycles + 1'b1;
    end else begin
      retired <= retired + CNT_W'(w_meta.valid);
      w_meta <= (e_busy && !flush) ? '0 : e_meta;
      if (flush) begin
        pc <= e_jump_dest;
        d_valid <= 1'b0;
        e_meta <= '0;
        flush_cycles <= flush_cycles + 1'b1;
      end else if (e_busy || hazard) begin
        stall_cycles <= stall_cycles + 1'b1;
        if (!e_busy) e_meta <= '0;
      end else begin
        pc <= pc + XLEN'(PC_STEP);
        d_valid <= 1'b1;
        e_meta <= d_meta;
      end
    end
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline controller for the four-stage core (F, D, E, W). It owns the PC, per-stage valid bits and stage-advance enables, and the rd metadata for instructions in flight. It replaces stall-on-every-jump with predict-not-taken plus flush, adds load-use interlock, multi-cycle execute hold, external freeze, and operand-forwarding selects. It sits beside the stage modules in `core` and drives their enables; the datapath stays in the stages.

## Interface
Parameters:
- XLEN, 32, PC and jump-destination width
- RADDR_W, 5, register address width
- RESET_PC, 0, PC value after reset
- PC_STEP, 1, PC increment per fetch (word addressing)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- stall_ext  in  1  external freeze (memory not ready)
- d_rs1, d_rs2  in  RADDR_W  decode source addresses
- d_use_rs1, d_use_rs2  in  1  decode actually reads the source
- d_rd  in  RADDR_W  decode destination
- d_rd_we  in  1  decode writes rd
- d_is_load  in  1  decode instruction is a load
- e_busy  in  1  execute is multi-cycle and not done
- e_jump_taken  in  1  execute resolved a taken jump or branch
- e_jump_dest  in  XLEN  jump target
- pc  out  XLEN  fetch address
- f_en, d_en, e_en, w_en  out  1  stage advance enables
- d_valid, e_valid, w_valid  out  1  stage holds a live instruction
- fwd_rs1_sel, fwd_rs2_sel  out  2  0 = regfile, 1 = E result, 2 = W result
- retired, stall_cycles, flush_cycles  out  CNT_W  performance counters

## Operation
- Internal stage metadata for E and W: {valid, rd, rd_we, is_load}. It is captured from the d_* inputs when D advances into E, then shifted to W.
- Priority, highest first: rstn low, stall_ext, flush, e_busy, data hazard, normal advance.
- **stall_ext:** all enables 0. PC, valids and metadata hold. stall_cycles increments.
- **Flush:** taken when e_valid & !e_busy & e_jump_taken.
  - pc <= e_jump_dest.
  - Next cycle: d_valid = 0 and e_valid = 0, so the two younger instructions are killed.
  - The jump itself advances to W.
  - flush_cycles increments by 1 per flush.
- **e_busy:** f_en, d_en, e_en = 0. w_en = 1. A bubble enters W. stall_cycles increments.
- **Load-use hazard (FORWARD_EN only):** E is a valid load, E.rd == a used D source, and E.rd != 0.
  - F and D hold.
  - A bubble enters E.
  - stall_cycles increments.
- **Normal advance:**
  - pc <= pc + PC_STEP.
  - Valids shift: D takes 1, E takes d_valid, W takes e_valid.
- **Retire:** retired increments each cycle w_valid = 1 and w_en = 1.
- **Forwarding:**
  - sel = 1 if E is valid, E.rd_we, not a load, and E.rd == source.
  - Else sel = 2 if W is valid, W.rd_we, and W.rd == source.
  - Else sel = 0.
  - Source 0 always gives 0. E takes priority over W.
- Counters wrap at 2^CNT_W.
- e_jump_taken is ignored while e_busy = 1 or e_valid = 0.

## Timing
- **Reset values:**
  - pc = RESET_PC.
  - d_valid, e_valid, w_valid = 0.
  - All metadata = 0.
  - Counters = 0.
- **Outputs while rstn = 0:** enables and fwd selects = 0.
- **First cycle after reset:** f_en = 1.
- pc, valids and counters are registered. Enables and fwd selects are combinational from current state and inputs.
- **Latency:** fetch at cycle n reaches W at n+3 when there are no stalls.
- **Penalties:**
  - Taken jump: 2 cycles.
  - Load-use: 1 cycle.
  - Without FORWARD_EN, a back-to-back dependency: 2 cycles.
- **Simultaneous events:**
  - Flush and data hazard together: flush wins, because the hazard instruction is killed.
  - stall_ext and flush together: flush is deferred. State holds and the flush is re-evaluated next cycle.
- rstn low mid-operation clears all state at the next edge. In-flight instructions are discarded without retiring.

## Configuration
- Macro: PIPE_CTRL_FORWARD_EN.
- **Defined:** forwarding selects are live as above. Only load-use stalls for data hazards.
- **Undefined:**
  - fwd_rs1_sel and fwd_rs2_sel are tied to 0.
  - D stalls (F and D hold, bubble into E) while any used source != 0 matches the rd of a valid rd_we instruction in E or W.
  - The register file does not bypass same-cycle writes.

## Structure
- Package pipe_pkg holds:
  - fwd_sel_t enum {FWD_RF = 0, FWD_E = 1, FWD_W = 2}.
  - stage_meta_t struct {valid, rd, rd_we, is_load}.
  - XLEN and RADDR_W defaults.
- Sub-module pipe_hazard: purely combinational. It takes D sources plus E/W metadata and produces the hazard stall and fwd selects.
- pipe_ctrl holds all registers and the priority logic.

## Test plan
- **Reset then free run:** rstn low 2 cycles, then high with no hazards. pc = 0,1,2,…; w_valid first 1 at cycle 3; retired = 10 after 13 cycles.
- **Taken jump:** e_jump_taken = 1, dest = 0x40, at pc = 5. Next pc = 0x40; d_valid and e_valid = 0 for one cycle; flush_cycles = 1; retired excludes the 2 killed instructions.
- **RAW back-to-back:** E writes rd = 3 and D reads rs1 = 3. With FORWARD_EN: fwd_rs1_sel = 1 and no stall. Without: 2 stall cycles, stall_cycles = 2.
- **Load-use:** E is a load with rd = 7 and D reads rs2 = 7. One stall cycle, then fwd_rs2_sel = 2. Source x0 never forwards or stalls.
- **e_busy for 3 cycles during a flush request:** jump ignored until e_busy = 0, then flush. stall_cycles += 3; W bubbles for 3 cycles.
- **stall_ext with pending flush, then rstn low mid-stall:** state frozen while stall_ext is high. All valids = 0 and pc = RESET_PC after the reset edge.
